// File: rtl/spi_pkg.sv
// Shared SPI constants: default FIFO geometry, flag bit positions, and the
// log2 / flag-decode helpers used by the FIFO.
package spi_pkg;

    localparam int SPI_FIFO_DEPTH_DEF = 4;
    localparam int SPI_DWIDTH_DEF     = 8;

    localparam int FLG_EMPTY     = 0;
    localparam int FLG_EMPTY_NXT = 1;
    localparam int FLG_FULL_NXT  = 2;
    localparam int FLG_FULL      = 3;
    localparam int FLG_W         = 4;

    function automatic int spi_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic logic [FLG_W-1:0] spi_flags(input int unsigned cnt,
                                                   input int unsigned depth);
        logic [FLG_W-1:0] f;
        f                = '0;
        f[FLG_EMPTY]     = (cnt == 0);
        f[FLG_EMPTY_NXT] = (cnt == 1);
        f[FLG_FULL_NXT]  = (cnt == depth - 1);
        f[FLG_FULL]      = (cnt == depth);
        return f;
    endfunction

endpackage

// File: rtl/spi_fifo_buf_if.sv
// FIFO data/flag bundle between the register file (master) and the FIFO (slave).
interface spi_fifo_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 2
) ();
    logic              clr;
    logic              wr_en;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_data;
    logic              full;
    logic              full_next;
    logic              empty;
    logic              empty_next;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, full, full_next, empty, empty_next, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, full, full_next, empty, empty_next, count, overflow, underflow
    );
endinterface

// File: rtl/spi_fifo_buf_mem.sv
// DEPTH x DWIDTH FIFO storage. Read port is combinational when
// SPI_FIFO_FWFT_EN is defined, otherwise a registered port loaded on re.
module spi_fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

`ifdef SPI_FIFO_FWFT_EN
    logic w_unused_fwft;
    assign w_unused_fwft = re | rst_n;
    assign rdata         = r_mem[raddr];
`else
    logic [DWIDTH-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r_rdata <= '0;
        else if (re) r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;
`endif

endmodule

// File: rtl/spi_fifo_buf.sv
// Single-clock SPI TX/RX FIFO: pointers, explicit occupancy count, registered
// flags and overflow/underflow strobes. Optional macro: SPI_FIFO_FWFT_EN.
module spi_fifo_buf
    import spi_pkg::*;
#(
    parameter int DWIDTH = SPI_DWIDTH_DEF,
    parameter int DEPTH  = SPI_FIFO_DEPTH_DEF,
    parameter int AWIDTH = spi_log2(SPI_FIFO_DEPTH_DEF)
) (
    input  logic     pclk,
    input  logic     presetn,
    spi_fifo_if.slave bus
);

    generate
        if (AWIDTH != spi_log2(DEPTH) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geom
            $error("spi_fifo_buf: DEPTH must be a power of two >= 2 and AWIDTH == log2(DEPTH)");
        end
    endgenerate

    localparam logic [FLG_W-1:0] FLAGS_RST = spi_flags(0, DEPTH);

    logic [AWIDTH-1:0] r_wptr;
    logic [AWIDTH-1:0] r_rptr;
    logic [AWIDTH:0]   r_count;
    logic [FLG_W-1:0]  r_flags;
    logic              r_ovf;
    logic              r_unf;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AWIDTH:0]   w_cnt_nxt;

    assign w_wr_acc = bus.wr_en && !r_flags[FLG_FULL]  && !bus.clr;
    assign w_rd_acc = bus.rd_en && !r_flags[FLG_EMPTY] && !bus.clr;

    always_comb begin
        w_cnt_nxt = r_count;
        if (bus.clr)                   w_cnt_nxt = '0;
        else if (w_wr_acc && !w_rd_acc) w_cnt_nxt = r_count + 1'b1;
        else if (!w_wr_acc && w_rd_acc) w_cnt_nxt = r_count - 1'b1;
    end

    // Flags are decoded from the next count so they land in the same cycle as count.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_flags <= FLAGS_RST;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_flags <= spi_flags(int'(w_cnt_nxt), DEPTH);
            r_ovf   <= !bus.clr && bus.wr_en && r_flags[FLG_FULL];
            r_unf   <= !bus.clr && bus.rd_en && r_flags[FLG_EMPTY];
            if (bus.clr) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
                if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    spi_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (w_wr_acc),
        .waddr (r_wptr),
        .wdata (bus.wr_data),
        .re    (w_rd_acc),
        .raddr (r_rptr),
        .rdata (bus.rd_data)
    );

    assign bus.count      = r_count;
    assign bus.empty      = r_flags[FLG_EMPTY];
    assign bus.empty_next = r_flags[FLG_EMPTY_NXT];
    assign bus.full_next  = r_flags[FLG_FULL_NXT];
    assign bus.full       = r_flags[FLG_FULL];
    assign bus.overflow   = r_ovf;
    assign bus.underflow  = r_unf;

endmodule

// File: tb/tb_spi_fifo_buf.sv
// Randomized + directed bench for spi_fifo_buf against a queue-based model.
module tb_spi_fifo_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic pclk;
    logic presetn;

    spi_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    spi_fifo_buf #(.DWIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          n_chk;
    int          n_fail;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd;
    logic        exp_ovf;
    logic        exp_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, " count"},      32'(bus.count), 32'(n));
        check({tag, " empty"},      32'(bus.empty), 32'(n == 0));
        check({tag, " empty_next"}, 32'(bus.empty_next), 32'(n == 1));
        check({tag, " full_next"},  32'(bus.full_next), 32'(n == DEPTH - 1));
        check({tag, " full"},       32'(bus.full), 32'(n == DEPTH));
        check({tag, " overflow"},   32'(bus.overflow), 32'(exp_ovf));
        check({tag, " underflow"},  32'(bus.underflow), 32'(exp_unf));
`ifdef SPI_FIFO_FWFT_EN
        if (n > 0) check({tag, " rd_data"}, 32'(bus.rd_data), 32'(q[0]));
`else
        check({tag, " rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
`endif
    endtask

    // One clock with the given request; model applies the accept rules, then compare.
    task automatic cyc(input string tag, input logic wr, input logic [DW-1:0] wd,
                       input logic rd, input logic cl);
        int n;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        bus.clr     = cl;
        @(posedge pclk);
        n       = q.size();
        exp_ovf = !cl && wr && (n == DEPTH);
        exp_unf = !cl && rd && (n == 0);
        if (cl) q.delete();
        else begin
            if (rd && n > 0) exp_rd = q.pop_front();
            if (wr && n < DEPTH) q.push_back(wd);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] pat [4];
        n_chk       = 0;
        n_fail      = 0;
        exp_rd      = '0;
        exp_ovf     = 1'b0;
        exp_unf     = 1'b0;
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        presetn     = 1'b0;
        #12;
        check_all("reset");
        presetn = 1'b1;
        @(posedge pclk); #1;

        // 1: idle, then underflow
        cyc("idle", 0, 8'h00, 0, 0);
        cyc("unf", 0, 8'h00, 1, 0);
        cyc("unf_clear", 0, 8'h00, 0, 0);

        // 2: fill and overflow
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        for (int i = 0; i < 4; i++) cyc("fill", 1, pat[i], 0, 0);
        cyc("ovf", 1, 8'hEE, 0, 0);
        cyc("ovf_clear", 0, 8'h00, 0, 0);

        // 3: drain, refill across the pointer wrap, drain again
        for (int i = 0; i < 4; i++) cyc("drain", 0, 8'h00, 1, 0);
        cyc("drain_idle", 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cyc("refill", 1, 8'(8'h11 + i), 0, 0);
        cyc("full_rw", 1, 8'h77, 1, 0);
        for (int i = 0; i < 4; i++) cyc("drain2", 0, 8'h00, 1, 0);
        cyc("empty_rw", 1, 8'h88, 1, 0);
        cyc("drain3", 0, 8'h00, 1, 0);

        // 4: steady simultaneous read/write at count 2
        cyc("pre2", 1, 8'h21, 0, 0);
        cyc("pre2", 1, 8'h22, 0, 0);
        for (int i = 0; i < 8; i++) cyc("rw2", 1, 8'(8'h30 + i), 1, 0);

        // 5: clr with a coincident write at count 3
        cyc("pre3", 1, 8'h40, 0, 0);
        cyc("clr", 1, 8'h99, 0, 1);
        cyc("post_clr", 0, 8'h00, 0, 0);

        // 6: async reset mid-burst at count 2
        cyc("burst", 1, 8'h61, 0, 0);
        cyc("burst", 1, 8'h62, 0, 0);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h63;
        #2 presetn = 1'b0;
        #1;
        q.delete();
        exp_rd  = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all("async_rst");
        bus.wr_en = 1'b0;
        #3 presetn = 1'b1;
        @(posedge pclk); #1;
        cyc("fresh_wr", 1, 8'h5A, 0, 0);
        cyc("fresh_rd", 0, 8'h00, 1, 0);
        cyc("fresh_idle", 0, 8'h00, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
